mult_pipe: RTL and testbench

- Five-stage integer multiply pipeline (M1..M5) fed from the decode/issue stage in parallel with the EX/MEM path.
- Computes the low 32 bits of rs*rt over four partial-product stages and retires from M5 through a dedicated register-file write port.
- Exports per-stage destination register and write-enable for the mult hazard unit, so it can detect RAW/WAW stalls against in-flight multiplies.

---
 rtl/mult_pipe_pkg.sv | 35 +++
 rtl/mult_pipe_stage.sv | 32 +++
 rtl/mult_pipe.sv | 96 +++++++++
 tb/tb_mult_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared widths, stage record layout and the byte partial-product helper
package mult_pipe_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int MULT_STAGES = 5;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [DATA_W-1:0]     acc;
    } stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     acc;
    } result_t;

    // (a * b[byte idx]) << 8*idx, truncated to the low word
    function automatic logic [DATA_W-1:0] partial(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input int                idx
    );
        logic [DATA_W-1:0] bb;
        bb = DATA_W'(b[8*idx +: 8]);
        return (a * bb) << (8 * idx);
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_stage: one pipeline slice adding the partial product of operand byte BYTE_IDX
module mult_stage
    import mult_pipe_pkg::*;
#(
    parameter int BYTE_IDX = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    stage_t stage_d, stage_q;

    // pass the record through, accumulating this slice's byte product
    always_comb begin
        stage_d     = stage_i;
        stage_d.acc = stage_i.acc + partial(stage_i.a, stage_i.b, BYTE_IDX);
    end

    // slice register, frozen while the pipeline is held
    always_ff @(posedge clk) begin
        if (rst)
            stage_q <= '0;
        else if (!hold_i)
            stage_q <= stage_d;
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: five-stage low-word integer multiplier with hazard taps and a write-back port
module mult_pipe
    import mult_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dst_reg,
    input  logic                  issue_regwrite,
    input  logic [DATA_W-1:0]     issue_src_a,
    input  logic [DATA_W-1:0]     issue_src_b,
    input  logic                  flush,
    input  logic                  hold,
    output logic [REG_ADDR_W-1:0] m1_dst_reg,
    output logic [REG_ADDR_W-1:0] m2_dst_reg,
    output logic [REG_ADDR_W-1:0] m3_dst_reg,
    output logic [REG_ADDR_W-1:0] m4_dst_reg,
    output logic [REG_ADDR_W-1:0] m5_dst_reg,
    output logic                  m1_regwrite,
    output logic                  m2_regwrite,
    output logic                  m3_regwrite,
    output logic                  m4_regwrite,
    output logic                  m5_regwrite,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic [2:0]            inflight
);

    stage_t  issue_stage;
    stage_t  stg [MULT_STAGES-1];
    result_t m5_d, m5_q;
    logic [2:0] inflight_d, inflight_q;
    logic unused_m4_operands;

    // build the M1 entry; a flushed issue becomes a bubble
    always_comb begin
        issue_stage = '{valid:    issue_valid & ~flush,
                        regwrite: issue_regwrite,
                        dst:      issue_dst_reg,
                        a:        issue_src_a,
                        b:        issue_src_b,
                        acc:      '0};
    end

    mult_stage #(.BYTE_IDX(0)) u_m1 (.clk(clk), .rst(rst), .hold_i(hold), .stage_i(issue_stage), .stage_o(stg[0]));
    mult_stage #(.BYTE_IDX(1)) u_m2 (.clk(clk), .rst(rst), .hold_i(hold), .stage_i(stg[0]),      .stage_o(stg[1]));
    mult_stage #(.BYTE_IDX(2)) u_m3 (.clk(clk), .rst(rst), .hold_i(hold), .stage_i(stg[1]),      .stage_o(stg[2]));
    mult_stage #(.BYTE_IDX(3)) u_m4 (.clk(clk), .rst(rst), .hold_i(hold), .stage_i(stg[2]),      .stage_o(stg[3]));

    // M5 keeps only what write-back and the hazard unit need
    always_comb begin
        m5_d = '{valid: stg[3].valid, regwrite: stg[3].regwrite, dst: stg[3].dst, acc: stg[3].acc};
    end

    assign unused_m4_operands = ^{stg[3].a, stg[3].b};

    // M5 result register
    always_ff @(posedge clk) begin
        if (rst)
            m5_q <= '0;
        else if (!hold)
            m5_q <= m5_d;
    end

    // occupancy: count entries entering M1 minus the one leaving M5
    always_comb begin
        inflight_d = inflight_q + 3'(issue_stage.valid) - 3'(m5_q.valid);
    end

    // occupancy register, frozen with the stages
    always_ff @(posedge clk) begin
        if (rst)
            inflight_q <= '0;
        else if (!hold)
            inflight_q <= inflight_d;
    end

    assert property (@(posedge clk) disable iff (rst) inflight_q <= 3'd5);

    assign m1_dst_reg  = stg[0].dst;
    assign m2_dst_reg  = stg[1].dst;
    assign m3_dst_reg  = stg[2].dst;
    assign m4_dst_reg  = stg[3].dst;
    assign m5_dst_reg  = m5_q.dst;
    assign m1_regwrite = stg[0].valid & stg[0].regwrite;
    assign m2_regwrite = stg[1].valid & stg[1].regwrite;
    assign m3_regwrite = stg[2].valid & stg[2].regwrite;
    assign m4_regwrite = stg[3].valid & stg[3].regwrite;
    assign m5_regwrite = m5_q.valid & m5_q.regwrite;
    assign wb_en       = m5_regwrite;
    assign wb_reg      = m5_q.dst;
    assign wb_data     = m5_q.acc;
    assign inflight    = inflight_q;

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed scenario bench for the multiply pipeline
module tb_mult_pipe;

    logic        clk = 1'b0;
    logic        rst, issue_valid, issue_regwrite, flush, hold;
    logic [4:0]  issue_dst_reg;
    logic [31:0] issue_src_a, issue_src_b;
    logic [4:0]  m1_dst_reg, m2_dst_reg, m3_dst_reg, m4_dst_reg, m5_dst_reg;
    logic        m1_regwrite, m2_regwrite, m3_regwrite, m4_regwrite, m5_regwrite;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [2:0]  inflight;
    int tests = 0;
    int fails = 0;

    mult_pipe dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_dst_reg(issue_dst_reg),
        .issue_regwrite(issue_regwrite), .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
        .flush(flush), .hold(hold),
        .m1_dst_reg(m1_dst_reg), .m2_dst_reg(m2_dst_reg), .m3_dst_reg(m3_dst_reg),
        .m4_dst_reg(m4_dst_reg), .m5_dst_reg(m5_dst_reg),
        .m1_regwrite(m1_regwrite), .m2_regwrite(m2_regwrite), .m3_regwrite(m3_regwrite),
        .m4_regwrite(m4_regwrite), .m5_regwrite(m5_regwrite),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dst_of(input int k);
        case (k)
            1: return m1_dst_reg;
            2: return m2_dst_reg;
            3: return m3_dst_reg;
            4: return m4_dst_reg;
            default: return m5_dst_reg;
        endcase
    endfunction

    function automatic logic rw_of(input int k);
        case (k)
            1: return m1_regwrite;
            2: return m2_regwrite;
            3: return m3_regwrite;
            4: return m4_regwrite;
            default: return m5_regwrite;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] dst, input logic rw, input logic [31:0] a, input logic [31:0] b);
        issue_valid    = 1'b1;
        issue_dst_reg  = dst;
        issue_regwrite = rw;
        issue_src_a    = a;
        issue_src_b    = b;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_dst_reg  = '0;
        issue_regwrite = 1'b0;
        issue_src_a    = '0;
        issue_src_b    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tests++; if (wb_en !== 1'b0) begin fails++; $display("FAIL reset_wb_en got=%0b exp=0", wb_en); end
        tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        tests++; if (wb_data !== 32'h0) begin fails++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        for (int k = 1; k <= 5; k++) begin
            tests++; if (rw_of(k) !== 1'b0 || dst_of(k) !== 5'd0) begin
                fails++; $display("FAIL reset_m%0d got rw=%0b dst=%0d exp rw=0 dst=0", k, rw_of(k), dst_of(k));
            end
        end
    endtask

    task automatic test_single();
        issue(5'd7, 1'b1, 32'h0000_1234, 32'h0000_5678);
        tick();
        idle();
        for (int k = 1; k <= 5; k++) begin
            tests++; if (dst_of(k) !== 5'd7 || rw_of(k) !== 1'b1) begin
                fails++; $display("FAIL single_m%0d got rw=%0b dst=%0d exp rw=1 dst=7", k, rw_of(k), dst_of(k));
            end
            tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL single_inflight_m%0d got=%0d exp=1", k, inflight); end
            tests++; if (wb_en !== (k == 5)) begin fails++; $display("FAIL single_wb_en_m%0d got=%0b exp=%0b", k, wb_en, k == 5); end
            if (k < 5) tick();
        end
        tests++; if (wb_reg !== 5'd7) begin fails++; $display("FAIL single_wb_reg got=%0d exp=7", wb_reg); end
        tests++; if (wb_data !== 32'h0626_0060) begin fails++; $display("FAIL single_wb_data got=%h exp=06260060", wb_data); end
        tick();
        tests++; if (inflight !== 3'd0 || wb_en !== 1'b0) begin
            fails++; $display("FAIL single_drain got inflight=%0d wb_en=%0b exp 0 0", inflight, wb_en);
        end
    endtask

    task automatic test_back_to_back();
        issue(5'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        issue(5'd4, 1'b1, 32'h8000_0000, 32'h0000_0002);
        tick();
        idle();
        tests++; if (inflight !== 3'd2) begin fails++; $display("FAIL b2b_peak got=%0d exp=2", inflight); end
        tests++; if (m1_dst_reg !== 5'd4 || m2_dst_reg !== 5'd3) begin
            fails++; $display("FAIL b2b_dst got m1=%0d m2=%0d exp 4 3", m1_dst_reg, m2_dst_reg);
        end
        tick(); tick(); tick();
        tests++; if (wb_en !== 1'b1 || wb_reg !== 5'd3 || wb_data !== 32'h1) begin
            fails++; $display("FAIL b2b_first got en=%0b reg=%0d data=%h exp 1 3 00000001", wb_en, wb_reg, wb_data);
        end
        tests++; if (inflight !== 3'd2) begin fails++; $display("FAIL b2b_inflight_first got=%0d exp=2", inflight); end
        tick();
        tests++; if (wb_en !== 1'b1 || wb_reg !== 5'd4 || wb_data !== 32'h0) begin
            fails++; $display("FAIL b2b_second got en=%0b reg=%0d data=%h exp 1 4 00000000", wb_en, wb_reg, wb_data);
        end
        tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL b2b_inflight_second got=%0d exp=1", inflight); end
        tick();
        tests++; if (inflight !== 3'd0 || wb_en !== 1'b0) begin
            fails++; $display("FAIL b2b_drain got inflight=%0d wb_en=%0b exp 0 0", inflight, wb_en);
        end
    endtask

    task automatic test_hold();
        issue(5'd5, 1'b1, 32'h0000_0003, 32'h0101_0101);
        tick();
        idle();
        tick(); tick();
        tests++; if (m3_dst_reg !== 5'd5 || m3_regwrite !== 1'b1) begin
            fails++; $display("FAIL hold_pre got m3 rw=%0b dst=%0d exp 1 5", m3_regwrite, m3_dst_reg);
        end
        hold = 1'b1;
        issue(5'd12, 1'b1, 32'h1111_1111, 32'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            tick();
            tests++; if (m3_dst_reg !== 5'd5 || m3_regwrite !== 1'b1 || m1_regwrite !== 1'b0 || m4_regwrite !== 1'b0 || inflight !== 3'd1) begin
                fails++; $display("FAIL hold_freeze_%0d got m3 rw=%0b dst=%0d m1rw=%0b m4rw=%0b inflight=%0d exp 1 5 0 0 1",
                                  i, m3_regwrite, m3_dst_reg, m1_regwrite, m4_regwrite, inflight);
            end
        end
        hold = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tests++; if (m4_dst_reg !== 5'd5 || wb_en !== 1'b0) begin
            fails++; $display("FAIL hold_m4 got dst=%0d wb_en=%0b exp 5 0", m4_dst_reg, wb_en);
        end
        tick();
        tests++; if (wb_en !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'h0303_0303) begin
            fails++; $display("FAIL hold_wb got en=%0b reg=%0d data=%h exp 1 5 03030303", wb_en, wb_reg, wb_data);
        end
        tick();
        tests++; if (wb_en !== 1'b0 || inflight !== 3'd0) begin
            fails++; $display("FAIL hold_once got wb_en=%0b inflight=%0d exp 0 0", wb_en, inflight);
        end
    endtask

    task automatic test_flush();
        issue(5'd6, 1'b1, 32'h5, 32'h7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        tests++; if (m1_regwrite !== 1'b0 || inflight !== 3'd0) begin
            fails++; $display("FAIL flush_m1 got rw=%0b inflight=%0d exp 0 0", m1_regwrite, inflight);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (wb_en !== 1'b0 || inflight !== 3'd0) begin
                fails++; $display("FAIL flush_drain_%0d got wb_en=%0b inflight=%0d exp 0 0", i, wb_en, inflight);
            end
        end
    endtask

    task automatic test_no_regwrite();
        issue(5'd9, 1'b0, 32'h2, 32'h3);
        tick();
        idle();
        for (int k = 1; k <= 5; k++) begin
            tests++; if (rw_of(k) !== 1'b0 || dst_of(k) !== 5'd9 || inflight !== 3'd1 || wb_en !== 1'b0) begin
                fails++; $display("FAIL norw_m%0d got rw=%0b dst=%0d inflight=%0d wb_en=%0b exp 0 9 1 0",
                                  k, rw_of(k), dst_of(k), inflight, wb_en);
            end
            tick();
        end
        tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL norw_drain got=%0d exp=0", inflight); end
    endtask

    task automatic test_fill_reset();
        for (int i = 1; i <= 5; i++) begin
            issue(5'(i), 1'b1, 32'(i), 32'h3);
            tick();
        end
        idle();
        tests++; if (inflight !== 3'd5) begin fails++; $display("FAIL fill_inflight got=%0d exp=5", inflight); end
        for (int k = 1; k <= 5; k++) begin
            tests++; if (rw_of(k) !== 1'b1 || dst_of(k) !== 5'(6 - k)) begin
                fails++; $display("FAIL fill_m%0d got rw=%0b dst=%0d exp 1 %0d", k, rw_of(k), dst_of(k), 6 - k);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (wb_en !== 1'b0 || inflight !== 3'd0) begin
            fails++; $display("FAIL fill_rst got wb_en=%0b inflight=%0d exp 0 0", wb_en, inflight);
        end
        for (int k = 1; k <= 5; k++) begin
            tests++; if (rw_of(k) !== 1'b0) begin fails++; $display("FAIL fill_rst_m%0d got rw=%0b exp 0", k, rw_of(k)); end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (wb_en !== 1'b0) begin fails++; $display("FAIL fill_after_rst_%0d got wb_en=%0b exp 0", i, wb_en); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_flush();
        test_no_regwrite();
        test_fill_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
